// File: rtl/nco_phase_accumulator.sv
// ============================================================================
// Module      : nco_phase_accumulator
// Description : NCO phase accumulator with I/Q phase words, square-wave
//               lock-in references and a per-period wrap strobe. Optional
//               LFSR phase dither enabled by defining PHASE_DITHER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nco_phase_accumulator #(
  parameter int ACC_W      = 24,
  parameter int FREQ_W     = 20,
  parameter int OUT_W      = 12,
  parameter int FREQ_RESET = 12623
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_en,
  input  logic [FREQ_W-1:0] freq_word,
  input  logic              freq_update_mode,
  input  logic              sync_clear,
  input  logic [OUT_W-1:0]  phase_offset,
  output logic [OUT_W-1:0]  phase_out,
  output logic [OUT_W-1:0]  phase_q_out,
  output logic              ref_i,
  output logic              ref_q,
  output logic              wrap_pulse,
  output logic              out_valid,
  output logic              freq_pending
);

  localparam int               c_FRAC_W  = ACC_W - OUT_W;
  localparam logic [OUT_W-1:0] c_QUARTER = OUT_W'(1) << (OUT_W - 2);

  logic [ACC_W-1:0]  r_acc;
  logic [FREQ_W-1:0] r_active_inc;
  logic              r_s1_valid;
  logic              r_s1_carry;
  logic [OUT_W-1:0]  r_phase;
  logic [OUT_W-1:0]  r_phase_q;
  logic              r_wrap;
  logic              r_valid;

  logic [ACC_W:0]    w_sum;
  logic              w_carry;
  logic              w_adopt;
  logic [OUT_W-1:0]  w_phase_trunc;
  logic [OUT_W-1:0]  w_phase_sum;

  assign w_sum   = {1'b0, r_acc} + (ACC_W+1)'(r_active_inc);
  assign w_carry = w_sum[ACC_W];
  // A zero increment never wraps, so deferred adoption would stall forever.
  assign w_adopt = freq_update_mode | (tick_en & w_carry) | (r_active_inc == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc        <= '0;
      r_active_inc <= FREQ_W'(FREQ_RESET);
      r_s1_valid   <= 1'b0;
      r_s1_carry   <= 1'b0;
    end else begin
      r_s1_valid <= tick_en | sync_clear;
      if (sync_clear) begin
        r_acc        <= '0;
        r_active_inc <= freq_word;
        r_s1_carry   <= 1'b0;
      end else begin
        r_s1_carry <= tick_en & w_carry;
        if (tick_en) begin
          r_acc <= w_sum[ACC_W-1:0];
        end
        if (w_adopt) begin
          r_active_inc <= freq_word;
        end
      end
    end
  end

`ifdef PHASE_DITHER_EN
  localparam int c_DITHER_W = (c_FRAC_W < 16) ? c_FRAC_W : 16;

  logic [15:0]      r_lfsr;
  logic [ACC_W-1:0] w_acc_dith;

  // Galois LFSR, taps 16,14,13,11 (right-shifting, mask 0xB400).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else if (tick_en) begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign w_acc_dith    = r_acc + ACC_W'(r_lfsr[c_DITHER_W-1:0]);
  assign w_phase_trunc = w_acc_dith[ACC_W-1 -: OUT_W];
`else
  assign w_phase_trunc = r_acc[ACC_W-1 -: OUT_W];
`endif

  assign w_phase_sum = w_phase_trunc + phase_offset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase   <= '0;
      r_phase_q <= c_QUARTER;
      r_wrap    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= r_s1_valid;
      r_wrap  <= r_s1_carry;
      if (r_s1_valid) begin
        r_phase   <= w_phase_sum;
        r_phase_q <= w_phase_sum + c_QUARTER;
      end
    end
  end

  assign phase_out    = r_phase;
  assign phase_q_out  = r_phase_q;
  assign ref_i        = r_phase[OUT_W-1];
  assign ref_q        = r_phase_q[OUT_W-1];
  assign wrap_pulse   = r_wrap;
  assign out_valid    = r_valid;
  assign freq_pending = (freq_word != r_active_inc);

endmodule

`default_nettype wire

// File: tb/tb_nco_phase_accumulator.sv
// ============================================================================
// Module      : tb_nco_phase_accumulator
// Description : Self-checking bench for nco_phase_accumulator (default build,
//               PHASE_DITHER_EN undefined) against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nco_phase_accumulator;

  localparam longint c_MOD     = 64'd1 << 24;
  localparam longint c_OUT_MOD = 4096;

  logic        clk;
  logic        reset;
  logic        tick_en;
  logic [19:0] freq_word;
  logic        freq_update_mode;
  logic        sync_clear;
  logic [11:0] phase_offset;
  logic [11:0] phase_out;
  logic [11:0] phase_q_out;
  logic        ref_i;
  logic        ref_q;
  logic        wrap_pulse;
  logic        out_valid;
  logic        freq_pending;

  nco_phase_accumulator dut (
    .clk              (clk),
    .reset            (reset),
    .tick_en          (tick_en),
    .freq_word        (freq_word),
    .freq_update_mode (freq_update_mode),
    .sync_clear       (sync_clear),
    .phase_offset     (phase_offset),
    .phase_out        (phase_out),
    .phase_q_out      (phase_q_out),
    .ref_i            (ref_i),
    .ref_q            (ref_q),
    .wrap_pulse       (wrap_pulse),
    .out_valid        (out_valid),
    .freq_pending     (freq_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: accumulator value, active increment, last sample info.
  longint m_acc;
  longint m_inc;
  bit     m_pend;
  bit     m_pend_carry;
  longint e_phase;
  longint e_q;
  bit     e_valid;
  bit     e_wrap;

  int     n_valid;
  bit     prev_ref;
  int     wrap_at[$];
  int     toggles[$];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_inc = 12623; m_pend = 0; m_pend_carry = 0;
    e_phase = 0; e_q = 1024; e_valid = 0; e_wrap = 0;
    n_valid = 0; prev_ref = 0;
    wrap_at.delete(); toggles.delete();
  endtask

  task automatic model_edge();
    longint s;
    bit     wrapped;
    e_valid = m_pend;
    e_wrap  = m_pend_carry;
    if (m_pend) begin
      e_phase = ((m_acc / 4096) + longint'(phase_offset)) % c_OUT_MOD;
      e_q     = (e_phase + 1024) % c_OUT_MOD;
    end
    if (sync_clear) begin
      m_acc = 0; m_inc = longint'(freq_word);
      m_pend = 1; m_pend_carry = 0;
    end else begin
      s       = m_acc + m_inc;
      wrapped = tick_en && (s >= c_MOD);
      if (freq_update_mode || wrapped || (m_inc == 0)) m_inc = longint'(freq_word);
      if (tick_en) m_acc = s % c_MOD;
      m_pend = tick_en; m_pend_carry = wrapped;
    end
  endtask

  task automatic compare_all();
    check("out_valid", out_valid, e_valid);
    check("wrap_pulse", wrap_pulse, e_wrap);
    check("phase_out", phase_out, e_phase);
    check("phase_q_out", phase_q_out, e_q);
    check("ref_i", ref_i, (e_phase >> 11) & 1);
    check("ref_q", ref_q, (e_q >> 11) & 1);
    check("freq_pending", freq_pending, longint'(freq_word) != m_inc);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    if (out_valid) begin
      n_valid++;
      if (wrap_pulse) wrap_at.push_back(n_valid);
      if (ref_i != prev_ref) toggles.push_back(n_valid);
      prev_ref = ref_i;
    end
  endtask

  task automatic run_ticks(input int n);
    tick_en = 1'b1;
    repeat (n) cycle();
    tick_en = 1'b0;
    cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    check("rst_phase_q", phase_q_out, 12'h400);
    check("rst_phase", phase_out, 0);
    reset   = 1'b0;
    tick_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick_en = 1'b0; sync_clear = 1'b0; freq_update_mode = 1'b0;
    freq_word = 20'd12623; phase_offset = '0;
    model_reset();

    // First tick after reset
    do_reset();
    run_ticks(1);
    check("first_phase", phase_out, 3);
    check("first_phase_q", phase_q_out, 12'h403);
    cycle();
    check("valid_one_shot", out_valid, 0);

    // Continuous ticks at the reset frequency: single wrap at tick 1330
    do_reset();
    run_ticks(1330);
    check("wrap_count", wrap_at.size(), 1);
    check("wrap_tick", (wrap_at.size() > 0) ? wrap_at[0] : -1, 1330);
    check("post_wrap_phase", phase_out, 11374 / 4096);

    // Mode 0: deferred adoption at the next wrap
    do_reset();
    run_ticks(100);
    freq_word = 20'h40000;
    cycle();
    check("m0_pending", freq_pending, 1);
    run_ticks(1229);
    check("m0_pending_pre_wrap", freq_pending, 1);
    run_ticks(1);
    check("m0_adopted", freq_pending, 0);
    wrap_at.delete(); toggles.delete();
    run_ticks(128);
    check("m0_wraps", wrap_at.size(), 2);
    if (wrap_at.size() == 2) begin
      check("m0_wrap_first", wrap_at[0], 1330 + 64);
      check("m0_wrap_period", wrap_at[1] - wrap_at[0], 64);
    end
    check("m0_toggles", toggles.size(), 4);
    for (int i = 1; i < toggles.size(); i++)
      check("m0_toggle_period", toggles[i] - toggles[i-1], 32);

    // Mode 1: immediate adoption
    freq_update_mode = 1'b1;
    freq_word = 20'h80000;
    cycle();
    check("m1_adopted", freq_pending, 0);
    wrap_at.delete(); toggles.delete();
    run_ticks(96);
    check("m1_wraps", wrap_at.size(), 3);
    for (int i = 1; i < wrap_at.size(); i++)
      check("m1_wrap_period", wrap_at[i] - wrap_at[i-1], 32);
    check("m1_toggles", toggles.size(), 6);
    for (int i = 1; i < toggles.size(); i++)
      check("m1_toggle_period", toggles[i] - toggles[i-1], 16);

    // sync_clear with simultaneous tick and phase offset
    sync_clear = 1'b1; tick_en = 1'b1; phase_offset = 12'h800;
    cycle();
    sync_clear = 1'b0; tick_en = 1'b0;
    cycle();
    check("sc_valid", out_valid, 1);
    check("sc_phase", phase_out, 12'h800);
    check("sc_ref_i", ref_i, 1);
    check("sc_phase_q", phase_q_out, 12'hC00);
    check("sc_ref_q", ref_q, 1);
    check("sc_wrap", wrap_pulse, 0);

    // Reset mid-stream
    freq_update_mode = 1'b0; freq_word = 20'd12623; phase_offset = '0;
    tick_en = 1'b1;
    repeat (20) cycle();
    do_reset();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_pending", freq_pending, 0);
    run_ticks(1);
    check("mid_rst_first_phase", phase_out, 3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick_en          = ($urandom % 4) != 0;
      sync_clear       = ($urandom % 64) == 0;
      freq_update_mode = ($urandom % 3) == 0;
      phase_offset     = 12'($urandom);
      if (($urandom % 40) == 0) begin
        case ($urandom % 4)
          0: freq_word = 20'h0;
          1: freq_word = 20'hFFFFF;
          2: freq_word = 20'h80000;
          default: freq_word = 20'($urandom);
        endcase
      end
      cycle();
    end
    tick_en = 1'b0; sync_clear = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
